// File: rtl/serdes_pkg.sv
// Shared serdes types and constants: serializer ratio, scheduler FSM states and
// an index-width helper that never returns zero.
package serdes_pkg;

    localparam int SER_RATIO         = 8;
    localparam int SCHED_GAP_DEFAULT = SER_RATIO;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} sched_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serdes_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request after ptr
// (wrapping modulo NUM_REQ) wins. The grant is one-hot, or zero if nothing is requesting.
module serdes_rr_arbiter
    import serdes_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic found_hi;
    logic found_lo;

    // Two passes: indices above ptr first, then the wrapped range 0..ptr.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req[i] && (i > int'(ptr))) begin
                found_hi = 1'b1;
                idx      = IW'(i);
            end
        end
        if (!found_hi) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_lo && req[i] && (i <= int'(ptr))) begin
                    found_lo = 1'b1;
                    idx      = IW'(i);
                end
            end
        end
        if (found_hi || found_lo)
            gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Round-robin scheduler that shares one serializer lane among NUM_REQ requesters, with a
// fixed guard gap after each issue. The optional per-requester grant counters are enabled by
// SERDES_SCHED_STATS_EN.
module serdes_tx_scheduler
    import serdes_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    parameter  int GAP_CYCLES = SCHED_GAP_DEFAULT,
    parameter  int CNT_WIDTH  = 16,
    localparam int IW         = idx_w(NUM_REQ)
) (
    input  logic                                pclk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [DATA_WIDTH-1:0]               ser_pdata,
    output logic                                ser_pdata_valid,
    output logic [IW-1:0]                       grant_id,
    output logic                                busy
`ifdef SERDES_SCHED_STATS_EN
    ,
    input  logic                                stats_clr,
    output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   grant_cnt
`endif
);

    localparam int GW = idx_w(GAP_CYCLES);

    sched_state_e         state, state_nxt;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        win_idx;
    logic [NUM_REQ-1:0]   win_gnt;
    logic [GW-1:0]        gap_cnt;
    logic                 xfer;

    serdes_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        xfer      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && |req_valid) begin
                    req_ready = win_gnt;
                    xfer      = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The word and index are captured only on a transfer and then held for the serializer.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= IW'(NUM_REQ - 1);
            ser_pdata <= '0;
            grant_id  <= '0;
            gap_cnt   <= '0;
        end else begin
            if (xfer) begin
                ser_pdata <= req_data[win_idx];
                grant_id  <= win_idx;
                ptr       <= win_idx;
            end
            if (state == S_ISSUE)
                gap_cnt <= GW'(GAP_CYCLES - 1);
            else if (state == S_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    assign ser_pdata_valid = (state == S_ISSUE);
    assign busy            = (state != S_IDLE);

`ifdef SERDES_SCHED_STATS_EN
    // Saturating counters; a clear takes priority over a grant in the same cycle.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (stats_clr) begin
            grant_cnt <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_gnt[i] && grant_cnt[i] != '1)
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Randomized and directed bench for serdes_tx_scheduler. A cycle-level transaction model
// (last-transfer time, RR pointer, counters) is compared against the DUT on every cycle.
module tb_serdes_tx_scheduler;
    import serdes_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 8;
`ifdef SERDES_SCHED_STATS_EN
    localparam int CW  = 2;
`else
    localparam int CW  = 16;
`endif

    logic                  pclk;
    logic                  rst_n;
    logic                  enable;
    logic [N-1:0]          req_valid;
    logic [N-1:0][DW-1:0]  req_data;
    logic [N-1:0]          req_ready;
    logic [DW-1:0]         ser_pdata;
    logic                  ser_pdata_valid;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  stats_clr;
`ifdef SERDES_SCHED_STATS_EN
    logic [N-1:0][CW-1:0]  grant_cnt;
`endif

    serdes_tx_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .GAP_CYCLES (GAP),
        .CNT_WIDTH  (CW)
    ) dut (
        .pclk            (pclk),
        .rst_n           (rst_n),
        .enable          (enable),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .ser_pdata       (ser_pdata),
        .ser_pdata_valid (ser_pdata_valid),
        .grant_id        (grant_id),
        .busy            (busy)
`ifdef SERDES_SCHED_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .grant_cnt       (grant_cnt)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: a transfer at cycle c makes the lane busy for cycles c+1 .. c+GAP+1,
    // with the issue pulse at c+1.
    int            cyc    = 0;
    int            m_last = -1000;
    int            m_ptr  = N - 1;
    int            m_gid  = 0;
    logic [DW-1:0] m_data = '0;
    int            m_cnt [N];

    always @(negedge pclk) begin
        int d, w, c;
        logic exp_busy, exp_vld;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            m_last = -1000;
            m_ptr  = N - 1;
            m_gid  = 0;
            m_data = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            chk("rst_valid", ser_pdata_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_gid", grant_id, 0);
            chk("rst_data", ser_pdata, 0);
        end else begin
            cyc++;
            d = cyc - m_last;
            exp_busy  = (d >= 1) && (d <= GAP + 1);
            exp_vld   = (d == 1);
            exp_ready = '0;
            w = -1;
            if (!exp_busy && enable && |req_valid) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (w < 0 && req_valid[c]) w = c;
                end
                exp_ready[w] = 1'b1;
            end
            chk("cyc_ready", req_ready, exp_ready);
            chk("cyc_valid", ser_pdata_valid, exp_vld);
            chk("cyc_busy", busy, exp_busy);
            chk("cyc_data", ser_pdata, m_data);
            chk("cyc_gid", grant_id, m_gid);
`ifdef SERDES_SCHED_STATS_EN
            for (int i = 0; i < N; i++) chk("cyc_cnt", grant_cnt[i], m_cnt[i]);
            if (stats_clr) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end else if (w >= 0 && m_cnt[w] < (1 << CW) - 1) begin
                m_cnt[w] = m_cnt[w] + 1;
            end
`endif
            if (w >= 0) begin
                m_last = cyc;
                m_ptr  = w;
                m_gid  = w;
                m_data = req_data[w];
            end
        end
    end

    task automatic do_reset();
        @(posedge pclk); #1;
        rst_n = 1'b0;
        @(posedge pclk); #1;
        rst_n = 1'b1;
    endtask

    // Returns at the falling edge of the cycle in which req_ready is seen.
    task automatic wait_grant(input string name, output int w, output longint t);
        bit got;
        got = 0;
        w   = -1;
        t   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge pclk);
            if (|req_ready) begin
                got = 1;
                t   = $time;
                for (int j = 0; j < N; j++) if (req_ready[j]) w = j;
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL %s: no grant within 40 cycles", name);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int      w, seen;
        longint  t, tprev;
        logic [31:0] rv;
        int exp2 [6] = '{0, 1, 2, 3, 0, 1};
        int exp3 [3] = '{3, 1, 3};

        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        stats_clr = 1'b0;
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;

        // Single word from requester 0
        @(posedge pclk); #1;
        enable      = 1'b1;
        req_valid   = 4'b0001;
        req_data[0] = 8'hA5;
        wait_grant("t1_grant", w, t);
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_winner", w, 0);
        @(posedge pclk); #1;
        req_valid   = '0;
        req_data[0] = 8'h3C;
        @(negedge pclk);
        chk("t1_pulse", ser_pdata_valid, 1);
        chk("t1_data", ser_pdata, 8'hA5);
        @(negedge pclk);
        chk("t1_pulse_end", ser_pdata_valid, 0);
        chk("t1_hold", ser_pdata, 8'hA5);

        // All requesters valid: strict rotation, transfers 10 cycles apart
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i] = DW'(8'h10 + i);
        tprev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_grant("t2_grant", w, t);
            chk("t2_order", w, exp2[k]);
            if (k > 0) chk("t2_spacing", (t - tprev) / 10, 10);
            tprev = t;
        end

        // Pointer now 1: only requesters 1 and 3
        @(posedge pclk); #1;
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_grant("t3_grant", w, t);
            chk("t3_order", w, exp3[k]);
        end

        // enable dropped during the gap
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge pclk);
            if (|req_ready) seen++;
        end
        chk("t4_no_grant", seen, 0);
        @(posedge pclk); #1;
        enable = 1'b1;
        @(negedge pclk);
        chk("t4_ready_same_cycle", req_ready, 4'b0010);

        // Asynchronous reset during the issue cycle
        @(posedge pclk); #2;
        chk("t5_pulse_pre", ser_pdata_valid, 1);
        chk("t5_gid_pre", grant_id, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", ser_pdata_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_gid", grant_id, 0);
        @(posedge pclk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        wait_grant("t5_grant", w, t);
        chk("t5_first", w, 0);

`ifdef SERDES_SCHED_STATS_EN
        // Counter saturation, then a clear that coincides with a grant
        do_reset();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            wait_grant("t6_grant", w, t);
            chk("t6_winner", w, 2);
        end
        @(negedge pclk);
        chk("t6_sat", grant_cnt[2], 3);
        repeat (9) @(posedge pclk);
        #1 stats_clr = 1'b1;
        @(negedge pclk);
        chk("t6_clr_ready", req_ready, 4'b0100);
        @(posedge pclk); #1;
        stats_clr = 1'b0;
        req_valid = '0;
        @(negedge pclk);
        chk("t6_clr_wins", grant_cnt[2], 0);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(posedge pclk); #1;
            rv        = $urandom;
            req_valid = rv[N-1:0];
            enable    = (rv[7:5] != 3'd0);
            stats_clr = (rv[12:8] == 5'd0);
            for (int j = 0; j < N; j++) begin
                rv          = $urandom;
                req_data[j] = rv[DW-1:0];
            end
        end
        @(posedge pclk); #1;
        req_valid = '0;
        stats_clr = 1'b0;
        repeat (3) @(posedge pclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
